// File: rtl/mccu_quota_regulator.sv
// Purpose : MemGuard-style quota regulator that reloads MCCU budgets periodically or by SW, and stalls a core that exhausts its quota.
// Latency : 1 cycle from reload to update_quota_o/quota_o, and from interruption to stall_req_o/irq_status_o/irq_o (all registered).
// Backpres: none; stall_req_o holds until the next reload (no timeout). Optional overrun counters are enabled with `define MCCU_REG_STATS_EN.
module mccu_quota_regulator #(
    parameter int DATA_WIDTH = 32,
    parameter int N_CORES    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic                                  enable_i,
    input  logic [DATA_WIDTH-1:0]                 period_i,
    input  logic [N_CORES-1:0][DATA_WIDTH-1:0]    budget_i,
    input  logic                                  sw_reload_i,
    input  logic [N_CORES-1:0]                    interruption_quota_i,
    output logic [N_CORES-1:0][DATA_WIDTH-1:0]    quota_o,
    output logic [N_CORES-1:0]                    update_quota_o,
    output logic [N_CORES-1:0]                    stall_req_o,
    input  logic [N_CORES-1:0]                    stall_ack_i,
    output logic                                  irq_o,
    output logic [N_CORES-1:0]                    irq_status_o,
    input  logic [N_CORES-1:0]                    irq_clear_i,
    output logic [N_CORES-1:0][CNT_WIDTH-1:0]     overrun_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RUN        = 2'd1,
        S_STALL_WAIT = 2'd2,
        S_STALLED    = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] period_cnt_q;
    logic                  enable_q;
    logic                  boundary;
    logic                  enable_rise;
    logic                  reload;

    state_t                state_q [N_CORES];
    state_t                state_d [N_CORES];
    logic [N_CORES-1:0]    ovr_set;
    logic [N_CORES-1:0]    stall_d;
    logic [N_CORES-1:0]    status_d;

    // A period of 0 disables automatic reloads; a shortened period only
    // takes effect once the counter wraps (possibly through all-ones).
    assign boundary    = enable_i && (period_i != '0) &&
                         (period_cnt_q == (period_i - DATA_WIDTH'(1)));
    assign enable_rise = enable_i && !enable_q;
    assign reload      = boundary || sw_reload_i || enable_rise;

    // Period counter: runs while enabled, parked at 0 while disabled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            period_cnt_q <= '0;
            enable_q     <= 1'b0;
        end else begin
            enable_q <= enable_i;
            if (!enable_i || boundary) begin
                period_cnt_q <= '0;
            end else begin
                period_cnt_q <= period_cnt_q + DATA_WIDTH'(1);
            end
        end
    end

    // Budget reload towards the MCCU: one-cycle update pulse, quota held in between.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            quota_o        <= '0;
            update_quota_o <= '0;
        end else begin
            update_quota_o <= {N_CORES{reload}};
            if (reload) begin
                quota_o <= budget_i;
            end
        end
    end

    // Per-core FSM next state; a reload always wins over interruption and ack.
    always_comb begin
        state_d = state_q;
        ovr_set = '0;
        stall_d = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (!enable_i) begin
                state_d[k] = S_IDLE;
            end else begin
                case (state_q[k])
                    S_IDLE: begin
                        state_d[k] = S_RUN;
                    end
                    S_RUN: begin
                        if (!reload && interruption_quota_i[k]) begin
                            state_d[k] = S_STALL_WAIT;
                            ovr_set[k] = 1'b1;
                        end
                    end
                    S_STALL_WAIT: begin
                        if (reload) begin
                            state_d[k] = S_RUN;
                        end else if (stall_ack_i[k]) begin
                            state_d[k] = S_STALLED;
                        end
                    end
                    S_STALLED: begin
                        if (reload) begin
                            state_d[k] = S_RUN;
                        end
                    end
                    default: begin
                        state_d[k] = S_IDLE;
                    end
                endcase
            end
            stall_d[k] = (state_d[k] == S_STALL_WAIT) || (state_d[k] == S_STALLED);
        end
    end

    // Sticky exhaustion flags: a new set beats a same-cycle W1C.
    assign status_d = (irq_status_o & ~irq_clear_i) | ovr_set;

    // FSM state register plus registered stall requests.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < N_CORES; k++) begin
                state_q[k] <= S_IDLE;
            end
            stall_req_o <= '0;
        end else begin
            for (int k = 0; k < N_CORES; k++) begin
                state_q[k] <= state_d[k];
            end
            stall_req_o <= stall_d;
        end
    end

    // Interrupt status and the aggregated line, updated together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_status_o <= '0;
            irq_o        <= 1'b0;
        end else begin
            irq_status_o <= status_d;
            irq_o        <= |status_d;
        end
    end

`ifdef MCCU_REG_STATS_EN
    logic [N_CORES-1:0][CNT_WIDTH-1:0] ovr_cnt_q;
    logic [N_CORES-1:0][CNT_WIDTH-1:0] ovr_cnt_d;

    // Saturating overrun counters; clear first, so clear+increment yields 1.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        for (int k = 0; k < N_CORES; k++) begin
            if (irq_clear_i[k]) begin
                ovr_cnt_d[k] = '0;
            end
            if (ovr_set[k] && (ovr_cnt_d[k] != {CNT_WIDTH{1'b1}})) begin
                ovr_cnt_d[k] = ovr_cnt_d[k] + CNT_WIDTH'(1);
            end
        end
    end

    // Overrun counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
`else
    assign overrun_cnt_o = '0;
`endif

endmodule
